// File: rtl/mac_pipe_param.sv
// mac_pipe_param: pipelined signed/unsigned multiply-accumulate with valid/ready handshake.
// Operand register -> MUL_STAGES product registers -> add/accumulate output register.
module mac_pipe_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int GUARD      = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [WIDTH-1:0]         in_c,
  input  logic                     in_signed,
  input  logic                     in_acc,
  input  logic                     in_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH+GUARD-1:0] out_result,
  output logic                     out_ovf
);

  localparam int RW = 2*WIDTH+GUARD;
  localparam int PW = 2*WIDTH;
  localparam int MW = WIDTH+3;   // op metadata: {c, signed, acc, clr}

  function automatic logic [PW-1:0] mul_ab(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sgn);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    bx = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [RW-1:0] ext_p(input logic [PW-1:0] p, input logic sgn);
    logic [RW-1:0] r;
    r = {RW{sgn & p[PW-1]}};
    r[PW-1:0] = p;
    return r;
  endfunction

  function automatic logic [RW-1:0] ext_c(input logic [WIDTH-1:0] c, input logic sgn);
    logic [RW-1:0] r;
    r = {RW{sgn & c[WIDTH-1]}};
    r[WIDTH-1:0] = c;
    return r;
  endfunction

  logic                  en_s;
  logic                  s0_vld_q;
  logic [WIDTH-1:0]      s0_a_q;
  logic [WIDTH-1:0]      s0_b_q;
  logic [MW-1:0]         s0_m_q;
  logic [MUL_STAGES-1:0] pv_q;
  logic [PW-1:0]         pp_q [MUL_STAGES];
  logic [MW-1:0]         pm_q [MUL_STAGES];
  logic                  out_valid_q;
  logic                  out_ovf_q;
  logic [RW-1:0]         out_result_q;
  logic [RW-1:0]         acc_q;
  logic [MW-1:0]         fin_m_s;
  logic [RW-1:0]         x_s;
  logic [RW-1:0]         p_s;
  logic [RW:0]           sum_s;
  logic                  ovf_d;

  assign en_s       = !out_valid_q || out_ready;
  assign in_ready   = en_s;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_ovf    = out_ovf_q;

  // Operand capture and product pipeline; everything freezes while the output is stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_vld_q <= 1'b0;
      s0_a_q   <= {WIDTH{1'b0}};
      s0_b_q   <= {WIDTH{1'b0}};
      s0_m_q   <= {MW{1'b0}};
      pv_q     <= {MUL_STAGES{1'b0}};
      for (int i = 0; i < MUL_STAGES; i++) begin
        pp_q[i] <= {PW{1'b0}};
        pm_q[i] <= {MW{1'b0}};
      end
    end else if (en_s) begin
      s0_vld_q <= in_valid;
      s0_a_q   <= in_a;
      s0_b_q   <= in_b;
      s0_m_q   <= {in_c, in_signed, in_acc, in_clr};
      pv_q[0]  <= s0_vld_q;
      pp_q[0]  <= mul_ab(s0_a_q, s0_b_q, s0_m_q[2]);
      pm_q[0]  <= s0_m_q;
      for (int i = 1; i < MUL_STAGES; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pm_q[i] <= pm_q[i-1];
      end
    end
  end

  // Final add: addend is ext(c) in fused mode, otherwise the (optionally cleared) accumulator.
  always_comb begin
    fin_m_s = pm_q[MUL_STAGES-1];
    p_s     = ext_p(pp_q[MUL_STAGES-1], fin_m_s[2]);
    if (fin_m_s[1]) begin
      if (fin_m_s[0]) begin
        x_s = {RW{1'b0}};
      end else begin
        x_s = acc_q;
      end
    end else begin
      x_s = ext_c(fin_m_s[MW-1:3], fin_m_s[2]);
    end
    sum_s = {1'b0, x_s} + {1'b0, p_s};
    if (fin_m_s[2]) begin
      ovf_d = (x_s[RW-1] == p_s[RW-1]) && (sum_s[RW-1] != x_s[RW-1]);
    end else begin
      ovf_d = sum_s[RW];
    end
  end

  // Output register and accumulator; acc only moves on a valid accumulate-mode op.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q  <= 1'b0;
      out_result_q <= {RW{1'b0}};
      out_ovf_q    <= 1'b0;
      acc_q        <= {RW{1'b0}};
    end else if (en_s) begin
      out_valid_q <= pv_q[MUL_STAGES-1];
      if (pv_q[MUL_STAGES-1]) begin
        out_result_q <= sum_s[RW-1:0];
        out_ovf_q    <= ovf_d;
        if (fin_m_s[1]) begin
          acc_q <= sum_s[RW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe_param.sv
// Scoreboard bench for mac_pipe_param: default instance plus an 8-bit/no-guard instance
// for the wrap/overflow case.
module tb_mac_pipe_param;

  typedef struct packed {
    logic [71:0] res;
    logic        ovf;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0, in_valid8 = 1'b0;
  logic        in_ready, in_ready8;
  logic [31:0] in_a = 32'd0, in_b = 32'd0, in_c = 32'd0;
  logic        in_signed = 1'b0, in_acc = 1'b0, in_clr = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_valid8;
  logic [71:0] out_result;
  logic [15:0] out_result8;
  logic        out_ovf, out_ovf8;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q8[$];
  exp_t e;

  always #5 CLK = ~CLK;

  mac_pipe_param u_dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_signed(in_signed), .in_acc(in_acc), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf)
  );

  mac_pipe_param #(.WIDTH(8), .MUL_STAGES(2), .GUARD(0)) u_dut8 (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_c(in_c[7:0]),
    .in_signed(in_signed), .in_acc(in_acc), .in_clr(in_clr),
    .out_valid(out_valid8), .out_ready(out_ready),
    .out_result(out_result8), .out_ovf(out_ovf8)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic issue(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic sg, input logic ac, input logic cl,
                       input bit push, input logic [71:0] er, input logic eo);
    int n;
    in_a = a; in_b = b; in_c = c;
    in_signed = sg; in_acc = ac; in_clr = cl;
    if (sel) in_valid8 = 1'b1;
    else     in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(sel ? in_ready8 : in_ready) && n < 200);
    if (!(sel ? in_ready8 : in_ready)) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end else if (push) begin
      if (sel) q8.push_back('{res: er, ovf: eo});
      else     q0.push_back('{res: er, ovf: eo});
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; in_valid8 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge CLK);
      n++;
    end
    n_tests++;
    if (q0.size() != 0 || q8.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0", q0.size(), q8.size());
    end
    @(posedge CLK); #1;
  endtask

  // Monitor: pop and compare on each handshake, check held value while stalled.
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_valid) begin
        if (q0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1 result=%h, expected no result", out_result);
        end else if (out_ready) begin
          e = q0.pop_front();
          chk("result", out_result, e.res);
          chk("ovf", {71'd0, out_ovf}, {71'd0, e.ovf});
        end else begin
          chk("hold_result", out_result, q0[0].res);
        end
      end
      if (out_valid8) begin
        if (q8.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid8: got out_valid=1 result=%h, expected no result", out_result8);
        end else if (out_ready) begin
          e = q8.pop_front();
          chk("result8", {56'd0, out_result8}, e.res);
          chk("ovf8", {71'd0, out_ovf8}, {71'd0, e.ovf});
        end else begin
          chk("hold_result8", {56'd0, out_result8}, q8[0].res);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", {71'd0, out_valid}, 72'd0);
    chk("rst_out_result", out_result, 72'd0);
    chk("rst_out_ovf", {71'd0, out_ovf}, 72'd0);
    chk("rst_in_ready", {71'd0, in_ready}, 72'd1);
    @(posedge CLK); #1;

    // 1: unsigned fused with latency check
    issue(1'b0, 32'd3, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1, 72'd17, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("latency_edge2", {71'd0, out_valid}, 72'd0);
    @(negedge CLK);
    chk("latency_edge3", {71'd0, out_valid}, 72'd1);
    drain();

    // 2: signed fused -2*3 + -1
    issue(1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1,
          72'hFF_FFFF_FFFF_FFFF_FFF9, 1'b0);
    drain();

    // 3: back-to-back accumulate, interleaved fused op leaves acc alone
    issue(1'b0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 72'd6, 1'b0);
    issue(1'b0, 32'd4, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd26, 1'b0);
    issue(1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd27, 1'b0);
    issue(1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 72'd1, 1'b0);
    issue(1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd28, 1'b0);
    drain();

    // 4: backpressure, 5 fused ops while out_ready is low for 6 cycles
    fork
      begin
        for (int i = 0; i < 5; i++)
          issue(1'b0, 32'd10 + 32'(i), 32'd2, 32'(i), 1'b0, 1'b0, 1'b0, 1'b1,
                72'd20 + 72'(3 * i), 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("stall_in_ready", {71'd0, in_ready}, 72'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // 5: 8-bit, no guard bits, unsigned accumulate wrap
    issue(1'b1, 32'd255, 32'd255, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 72'd65025, 1'b0);
    issue(1'b1, 32'd255, 32'd255, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd64514, 1'b1);
    drain();

    // 6: reset drops in-flight ops and clears acc
    issue(1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 72'd0, 1'b0);
    issue(1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 72'd0, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      seen = seen | out_valid;
    end
    chk("flush_no_valid", {71'd0, seen}, 72'd0);
    @(posedge CLK); #1;
    issue(1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 72'd1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
